// File: rtl/pid_output_stage.sv
// PID output stage: sums P/I/D contributions, saturates the result to a 6-bit
// signed control value, offsets it into a 0..63 duty and applies that duty to
// a 64-cycle PWM only at a period boundary so the output never glitches
// mid-period.
module pid_output_stage #(
  parameter int OFFSET = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       sample,
  input  logic [5:0] p_contrib,
  input  logic [5:0] i_contrib,
  input  logic [5:0] d_contrib,
  output logic       busy,
  output logic [5:0] u,
  output logic       sat,
  output logic [5:0] duty,
  output logic       pwm_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADD       = 2'd1,
    CLAMP     = 2'd2,
    WAIT_WRAP = 2'd3
  } state_t;

  localparam logic [5:0] OFFSET6 = 6'(OFFSET);

  state_t             state_reg;
  state_t             state_next;
  logic [5:0]         cnt_reg;
  logic [5:0]         p_reg;
  logic [5:0]         i_reg;
  logic [5:0]         d_reg;
  logic signed [7:0]  acc_reg;
  logic [5:0]         u_reg;
  logic               sat_reg;
  logic [5:0]         duty_reg;
  logic [5:0]         pending_reg;

  logic signed [7:0]  sum_next;
  logic [5:0]         u_next;
  logic               sat_next;
  logic               wrap_edge;

  // The PWM period ends on the enabled edge that takes cnt from 63 to 0.
  assign wrap_edge = ena && (cnt_reg == 6'd63);

  // Saturating final sum; 8 bits holds any p+i+d without overflow.
  always_comb begin
    sum_next = acc_reg + $signed({{2{d_reg[5]}}, d_reg});
    u_next   = sum_next[5:0];
    sat_next = 1'b0;
    if (sum_next > 8'sd31) begin
      u_next   = 6'd31;
      sat_next = 1'b1;
    end else if (sum_next < -8'sd32) begin
      u_next   = 6'b100000;
      sat_next = 1'b1;
    end
  end

  // State register: only advances on enabled edges, reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else if (ena) begin
      state_reg <= state_next;
    end
  end

  // Next-state logic for the capture / add / clamp / wait-for-wrap sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (sample) state_next = ADD;
      ADD:       state_next = CLAMP;
      CLAMP:     state_next = WAIT_WRAP;
      WAIT_WRAP: if (cnt_reg == 6'd63) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath and PWM counter; all of it freezes while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg     <= 6'd0;
      p_reg       <= 6'd0;
      i_reg       <= 6'd0;
      d_reg       <= 6'd0;
      acc_reg     <= 8'sd0;
      u_reg       <= 6'd0;
      sat_reg     <= 1'b0;
      duty_reg    <= 6'd0;
      pending_reg <= 6'd0;
    end else if (ena) begin
      cnt_reg <= cnt_reg + 6'd1;
      case (state_reg)
        IDLE: begin
          if (sample) begin
            p_reg <= p_contrib;
            i_reg <= i_contrib;
            d_reg <= d_contrib;
          end
        end
        ADD: begin
          acc_reg <= $signed({{2{p_reg[5]}}, p_reg}) + $signed({{2{i_reg[5]}}, i_reg});
        end
        CLAMP: begin
          u_reg       <= u_next;
          sat_reg     <= sat_next;
          pending_reg <= u_next + OFFSET6;
        end
        WAIT_WRAP: begin
          if (wrap_edge) duty_reg <= pending_reg;
        end
        default: ;
      endcase
    end
  end

  // Outputs: busy covers the whole capture-to-apply window, PWM gated by ena.
  always_comb begin
    busy    = (state_reg != IDLE);
    u       = u_reg;
    sat     = sat_reg;
    duty    = duty_reg;
    pwm_out = ena && (cnt_reg < duty_reg);
  end

endmodule

// File: tb/tb_pid_output_stage.sv
// Self-checking bench for pid_output_stage: directed scenarios plus random
// traffic, every cycle compared against a transaction-level reference model.
module tb_pid_output_stage;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       sample;
  logic [5:0] p_contrib;
  logic [5:0] i_contrib;
  logic [5:0] d_contrib;
  logic       busy;
  logic [5:0] u;
  logic       sat;
  logic [5:0] duty;
  logic       pwm_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (plain integers)
  int m_cnt, m_duty, m_pend, m_u, m_sat, m_busy, m_age;
  int m_p, m_i, m_d;

  pid_output_stage #(.OFFSET(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sample    (sample),
    .p_contrib (p_contrib),
    .i_contrib (i_contrib),
    .d_contrib (d_contrib),
    .busy      (busy),
    .u         (u),
    .sat       (sat),
    .duty      (duty),
    .pwm_out   (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour on one rising edge, using the inputs present at it.
  task automatic model_edge(input logic r, input logic e, input logic s,
                            input int p, input int i, input int d);
    int sum;
    if (!r) begin
      m_cnt = 0; m_duty = 0; m_pend = 0; m_u = 0; m_sat = 0;
      m_busy = 0; m_age = 0; m_p = 0; m_i = 0; m_d = 0;
    end else if (e) begin
      if (m_busy != 0) begin
        m_age++;
        if (m_age == 2) begin
          sum = m_p + m_i + m_d;
          if (sum > 31)       begin m_u = 31;  m_sat = 1; end
          else if (sum < -32) begin m_u = -32; m_sat = 1; end
          else                begin m_u = sum; m_sat = 0; end
          m_pend = ((m_u + 32) % 64 + 64) % 64;
        end else if (m_age > 2 && m_cnt == 63) begin
          m_duty = m_pend;
          m_busy = 0;
        end
      end else if (s) begin
        m_p = p; m_i = i; m_d = d;
        m_busy = 1;
        m_age = 0;
      end
      m_cnt = (m_cnt + 1) % 64;
    end
  endtask

  // Apply one cycle of inputs, advance model, compare all outputs at negedge.
  task automatic step(input logic r, input logic e, input logic s,
                      input int p, input int i, input int d);
    rst_n     = r;
    ena       = e;
    sample    = s;
    p_contrib = 6'(p);
    i_contrib = 6'(i);
    d_contrib = 6'(d);
    @(posedge clk);
    model_edge(r, e, s, p, i, d);
    @(negedge clk);
    chk("busy", int'(busy), m_busy);
    chk("u",    int'($signed(u)), m_u);
    chk("sat",  int'(sat), m_sat);
    chk("duty", int'(duty), m_duty);
    chk("pwm",  int'(pwm_out), (e && (m_cnt < m_duty)) ? 1 : 0);
    $display("rst_n=%0b ena=%0b smp=%0b p=%0d i=%0d d=%0d | busy=%0b u=%0d sat=%0b duty=%0d pwm=%0b",
             r, e, s, p, i, d, busy, $signed(u), sat, duty, pwm_out);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic go_to_cnt(input int c);
    for (int k = 0; k < 64 && m_cnt != c; k++) step(1'b1, 1'b1, 1'b0, 0, 0, 0);
  endtask

  // Wait (bounded) for the DUT to drop busy; counts enabled cycles taken.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      step(1'b1, 1'b1, 1'b0, 0, 0, 0);
      cycles++;
    end
    if (busy) chk("busy_timeout", 1, 0);
  endtask

  // Count pwm high cycles over one full period.
  task automatic count_pwm(output int hi);
    hi = 0;
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 1'b1, 1'b0, 0, 0, 0);
      if (pwm_out) hi++;
    end
  endtask

  task automatic directed(input int p, input int i, input int d,
                          input int exp_u, input int exp_sat, input int exp_duty);
    int cyc, hi;
    go_to_cnt(10);
    step(1'b1, 1'b1, 1'b1, p, i, d);
    run(2);
    chk("dir_u", int'($signed(u)), exp_u);
    chk("dir_sat", int'(sat), exp_sat);
    wait_idle(cyc);
    chk("dir_duty", int'(duty), exp_duty);
    count_pwm(hi);
    chk("dir_pwm_hi", hi, exp_duty);
  endtask

  initial begin
    int cyc, hi;
    int p, i, d;
    logic r, e, s;

    m_cnt = 0; m_duty = 0; m_pend = 0; m_u = 0; m_sat = 0;
    m_busy = 0; m_age = 0; m_p = 0; m_i = 0; m_d = 0;

    // Reset
    step(1'b0, 1'b1, 1'b1, 5, 5, 5);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_duty", int'(duty), 0);

    // Nominal, saturation high/low, intermediate overflow
    directed(5, 3, -2, 6, 0, 38);
    directed(31, 31, 31, 31, 1, 63);
    directed(-32, -32, -32, -32, 1, 0);
    directed(20, 20, -15, 25, 0, 57);

    // Second sample while busy is ignored
    go_to_cnt(20);
    step(1'b1, 1'b1, 1'b1, 1, 1, 1);
    run(3);
    step(1'b1, 1'b1, 1'b1, -20, -5, 7);
    wait_idle(cyc);
    chk("ignore_duty", int'(duty), 35);
    chk("ignore_u", int'($signed(u)), 3);

    // Enable low for 5 cycles mid-wait at cnt=40
    go_to_cnt(30);
    step(1'b1, 1'b1, 1'b1, 4, 4, 4);
    go_to_cnt(40);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b1, 9, 9, 9);
      chk("ena_lo_pwm", int'(pwm_out), 0);
    end
    wait_idle(cyc);
    chk("ena_lo_wrap_cycles", cyc, 24);
    chk("ena_lo_duty", int'(duty), 44);

    // Reset during CLAMP
    go_to_cnt(5);
    step(1'b1, 1'b1, 1'b1, 10, 0, 0);
    run(1);
    step(1'b0, 1'b1, 1'b0, 0, 0, 0);
    chk("rst_clamp_busy", int'(busy), 0);
    chk("rst_clamp_u", int'($signed(u)), 0);
    chk("rst_clamp_duty", int'(duty), 0);
    run(70);
    chk("rst_clamp_noupd", int'(duty), 0);

    // Reset during WAIT_WRAP
    step(1'b1, 1'b1, 1'b1, 7, 0, 0);
    run(5);
    step(1'b0, 1'b1, 1'b0, 0, 0, 0);
    chk("rst_wait_busy", int'(busy), 0);
    chk("rst_wait_u", int'($signed(u)), 0);
    chk("rst_wait_duty", int'(duty), 0);
    count_pwm(hi);
    chk("rst_wait_pwm_hi", hi, 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 4) == 0);
      p = $urandom_range(0, 63) - 32;
      i = $urandom_range(0, 63) - 32;
      d = $urandom_range(0, 63) - 32;
      step(r, e, s, p, i, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
